// File: rtl/mod_final_reduce_if.sv
// Operand/result handshake bundle for the final-reduction stage.
// master drives operands and consumes results; slave is the reducer.
interface mod_final_reduce_if #(
    parameter int unsigned IN_W   = 7,
    parameter int unsigned OUT_W  = 5,
    parameter int unsigned QUOT_W = 3
);
    logic [IN_W-1:0]   in_data;
    logic              in_valid;
    logic              in_ready;
    logic [OUT_W-1:0]  out_res;
    logic [QUOT_W-1:0] out_quot;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_res, out_quot, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_res, out_quot, out_valid
    );
endinterface

// File: rtl/mod_final_reduce.sv
// Final correction after group folding: subtracts MOD once per clock until the
// value is below MOD, then presents the residue and subtraction count.
module mod_final_reduce #(
    parameter int unsigned MOD    = 21,
    parameter int unsigned IN_W   = 7,
    parameter int unsigned OUT_W  = 5,
    parameter int unsigned QUOT_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    mod_final_reduce_if.slave bus
);
    localparam logic [IN_W-1:0] MOD_V = IN_W'(MOD);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   acc_q, acc_d;
    logic [QUOT_W-1:0] cnt_q, cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]  out_res_q, out_res_d;
    logic [QUOT_W-1:0] out_quot_q, out_quot_d;

    // State and datapath registers; reset clears any operand in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_quot_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_quot_q  <= out_quot_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_quot_d  = out_quot_q;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (bus.in_valid && in_ready_q) begin
                    acc_d      = bus.in_data;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = REDUCE;
                end
            end
            REDUCE: begin
                in_ready_d = 1'b0;
                if (acc_q >= MOD_V) begin
                    acc_d = acc_q - MOD_V;
                    cnt_d = cnt_q + QUOT_W'(1);
                end else begin
                    out_res_d   = acc_q[OUT_W-1:0];
                    out_quot_d  = cnt_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // Result held until consumed; next operand waits one more edge.
                in_ready_d = 1'b0;
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_res   = out_res_q;
    assign bus.out_quot  = out_quot_q;
endmodule
